reg_bank_write_arbiter: RTL and testbench

Owns a small bank of 8-bit registers and shares write access to it among several requesters. Arbitration is round-robin. Each requester presents a register index and write data, holds them with a request, and gets a one-cycle grant when its write has been committed. The block sits between independent producer logic and the register bank whose outputs feed downstream datapath logic.

---
 rtl/reg_bank_write_arbiter_pkg.sv | 13 +
 rtl/reg_bank_write_arbiter_rr_pick.sv | 27 ++
 rtl/reg_bank_write_arbiter.sv | 117 +++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared types and default constants for the round-robin register-bank write arbiter.
package reg_bank_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  localparam logic [DEF_DATA_W-1:0] DEF_RESET_VAL = 8'h00;

endpackage : reg_bank_write_arbiter_pkg

// File: rtl/reg_bank_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module reg_bank_write_arbiter_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               valid_o
);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    int idx;
    valid_o  = 1'b0;
    winner_o = '0;
    // Walk offsets downward so the smallest offset from the pointer is assigned last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule : reg_bank_write_arbiter_rr_pick

// File: rtl/reg_bank_write_arbiter.sv
// Register bank shared by NUM_REQ writers; one write per IDLE/WRITE pair, round-robin order.
module reg_bank_write_arbiter
  import reg_bank_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 3,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = DEF_RESET_VAL
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       err,
  output logic                       busy,
  output logic [NUM_REGS*DATA_W-1:0] q
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  bank_q [NUM_REGS];
  logic [DATA_W-1:0]  bank_d [NUM_REGS];

  logic [IDX_W-1:0]   pick_win;
  logic               pick_valid;

  reg_bank_write_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_win),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gnt_d   = '0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    bank_d  = bank_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_WRITE;
          win_d   = pick_win;
          addr_d  = req_addr[int'(pick_win)*ADDR_W +: ADDR_W];
          data_d  = req_data[int'(pick_win)*DATA_W +: DATA_W];
          // Outputs are registered, so they are loaded here to show during WRITE.
          gnt_d   = NUM_REQ'(1) << pick_win;
          err_d   = (int'(addr_d) >= NUM_REGS);
          busy_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (int'(addr_q) == k) bank_d[k] = data_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      // NOTE: the bank is architecturally visible, so each entry is reset explicitly.
      for (int k = 0; k < NUM_REGS; k++) bank_q[k] <= RESET_VAL;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) q[k*DATA_W +: DATA_W] = bank_q[k];
  end

  assign gnt  = gnt_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule : reg_bank_write_arbiter

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed bench for reg_bank_write_arbiter: reset, single write, round-robin, bad index, mid-write reset.
module tb_reg_bank_write_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int NUM_REGS = 3;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         gnt;
  logic                       err;
  logic                       busy;
  logic [NUM_REGS*DATA_W-1:0] q;

  int errors = 0;
  int checks = 0;

  reg_bank_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RESET_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .err      (err),
    .busy     (busy),
    .q        (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full clock: inputs driven before the rising edge, outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 3'b111;
    req_addr = '0;
    req_data = '0;

    // Reset held two cycles with all requests high.
    @(negedge clk);
    step();
    check("rst_q_c1",    32'(q),    32'h000000);
    check("rst_gnt_c1",  32'(gnt),  32'h0);
    check("rst_busy_c1", 32'(busy), 32'h0);
    step();
    check("rst_q_c2",    32'(q),    32'h000000);
    check("rst_gnt_c2",  32'(gnt),  32'h0);
    check("rst_busy_c2", 32'(busy), 32'h0);

    // Round-robin from pointer 0 with all three requesting.
    set_req(0, 2'd0, 8'h01);
    set_req(1, 2'd1, 8'h0F);
    set_req(2, 2'd2, 8'hF0);
    rst_n = 1'b1;
    step();
    check("rr_gnt0", 32'(gnt), 32'b001);
    check("rr_busy0", 32'(busy), 32'h1);
    step();
    check("rr_gap0", 32'(gnt), 32'b000);
    check("rr_q0", 32'(q), 32'h000001);
    step();
    check("rr_gnt1", 32'(gnt), 32'b010);
    step();
    check("rr_q1", 32'(q), 32'h000F01);
    step();
    check("rr_gnt2", 32'(gnt), 32'b100);
    step();
    check("rr_q2", 32'(q), 32'hF00F01);
    step();
    check("rr_gnt3", 32'(gnt), 32'b001);
    req = 3'b000;
    step();
    check("rr_final_q", 32'(q), 32'hF00F01);
    check("rr_final_busy", 32'(busy), 32'h0);

    // Single write from requester 1 (pointer is 1 now).
    set_req(1, 2'd1, 8'hAA);
    req = 3'b010;
    step();
    check("single_gnt", 32'(gnt), 32'b010);
    check("single_err", 32'(err), 32'h0);
    check("single_q_before", 32'(q), 32'hF00F01);
    req = 3'b000;
    step();
    check("single_gnt_drop", 32'(gnt), 32'b000);
    check("single_q_after", 32'(q), 32'hF0AA01);
    step();
    check("idle_busy", 32'(busy), 32'h0);

    // Pointer is 2 with only requesters 0 and 1 active: 0 must come first.
    set_req(0, 2'd0, 8'h11);
    set_req(1, 2'd2, 8'h22);
    req = 3'b011;
    step();
    check("fair_gnt_first", 32'(gnt), 32'b001);
    step();
    check("fair_q_first", 32'(q), 32'hF0AA11);
    req = 3'b010;
    step();
    check("fair_gnt_second", 32'(gnt), 32'b010);
    req = 3'b000;
    step();
    check("fair_q_second", 32'(q), 32'h22AA11);

    // Out-of-range index: grant and error together, bank untouched.
    set_req(0, 2'd3, 8'h99);
    req = 3'b001;
    step();
    check("bad_gnt", 32'(gnt), 32'b001);
    check("bad_err", 32'(err), 32'h1);
    req = 3'b000;
    step();
    check("bad_err_clear", 32'(err), 32'h0);
    check("bad_q", 32'(q), 32'h22AA11);

    // Reset lands on the edge that would commit requester 2's write.
    set_req(2, 2'd0, 8'h55);
    req = 3'b100;
    step();
    check("midrst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    step();
    check("midrst_gnt", 32'(gnt), 32'b000);
    check("midrst_q", 32'(q), 32'h000000);
    rst_n = 1'b1;
    step();
    check("midrst_regnt", 32'(gnt), 32'b100);
    req = 3'b000;
    step();
    check("midrst_q_final", 32'(q), 32'h000055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_bank_write_arbiter
